// File: rtl/soc_addr_decoder.sv
// rtl/soc_addr_decoder.sv - runtime-programmable rule-table address decoder with 2-stage lookup pipeline
module soc_addr_decoder #(
   parameter int unsigned NumRules  = 9,
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned IdxWidth  = (NumRules > 1) ? $clog2(NumRules) : 1,
   // Index 0 is the last element of each concatenation (DRAM); index 8 is Debug.
   parameter logic [NumRules-1:0][AddrWidth-1:0] RstBase = {
      64'h0000_0000_0000_0000,   // 8 Debug
      64'h0000_0000_0001_0000,   // 7 ROM
      64'h0000_0000_0200_0000,   // 6 CLINT
      64'h0000_0000_0C00_0000,   // 5 PLIC
      64'h0000_0000_1000_0000,   // 4 UART
      64'h0000_0000_2000_0000,   // 3 SPI
      64'h0000_0000_3000_0000,   // 2 Ethernet
      64'h0000_0000_4000_0000,   // 1 GPIO
      64'h0000_0000_8000_0000    // 0 DRAM
   },
   parameter logic [NumRules-1:0][AddrWidth-1:0] RstLength = {
      64'h0000_0000_0000_1000,
      64'h0000_0000_0001_0000,
      64'h0000_0000_000C_0000,
      64'h0000_0000_03FF_FFFF,
      64'h0000_0000_0000_1000,
      64'h0000_0000_0080_0000,
      64'h0000_0000_0001_0000,
      64'h0000_0000_0000_1000,
      64'h0000_0000_4000_0000
   }
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [IdxWidth-1:0]  resp_idx_o,
   output logic                 resp_hit_o,
   output logic                 resp_multi_o,
   input  logic                 cfg_we_i,
   input  logic [IdxWidth-1:0]  cfg_idx_i,
   input  logic [AddrWidth-1:0] cfg_base_i,
   input  logic [AddrWidth-1:0] cfg_len_i,
   input  logic                 cfg_lock_i,
   output logic                 cfg_locked_o,
   output logic                 cfg_err_o
);

   localparam logic [IdxWidth:0] NumRulesW = (IdxWidth + 1)'(NumRules);

   logic [AddrWidth-1:0] base_q [NumRules];
   logic [AddrWidth-1:0] len_q  [NumRules];
   logic                 locked_q;
   logic                 err_q;

   logic                 s1_valid_q;
   logic [NumRules-1:0]  s1_vec_q;
   logic                 s2_valid_q;
   logic [IdxWidth-1:0]  s2_idx_q;
   logic                 s2_hit_q;
   logic                 s2_multi_q;

   logic                 s1_adv;
   logic                 s2_adv;
   logic                 idx_ok;
   logic                 wr_ok;
   logic [NumRules-1:0]  match_vec;
   logic [IdxWidth-1:0]  enc_idx;
   logic                 enc_hit;
   logic                 enc_multi;

   assign s2_adv      = !s2_valid_q || resp_ready_i;
   assign s1_adv      = !s1_valid_q || s2_adv;
   assign req_ready_o = s1_adv;

   assign idx_ok = ({1'b0, cfg_idx_i} < NumRulesW);
   assign wr_ok  = cfg_we_i && !locked_q && idx_ok;

   // End address is formed one bit wider so regions touching the top of space never wrap.
   always_comb begin
      match_vec = '0;
      for (int i = 0; i < NumRules; i++) begin
         match_vec[i] = (len_q[i] != '0)
                     && (req_addr_i >= base_q[i])
                     && ({1'b0, req_addr_i} < ({1'b0, base_q[i]} + {1'b0, len_q[i]}));
      end
   end

   always_comb begin
      enc_idx   = '0;
      enc_hit   = 1'b0;
      enc_multi = 1'b0;
      for (int i = 0; i < NumRules; i++) begin
         if (s1_vec_q[i]) begin
            if (enc_hit) begin
               enc_multi = 1'b1;
            end else begin
               enc_idx = IdxWidth'(i);
            end
            enc_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumRules; i++) begin
            base_q[i] <= RstBase[i];
            len_q[i]  <= RstLength[i];
         end
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_vec_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_idx_q   <= '0;
         s2_hit_q   <= 1'b0;
         s2_multi_q <= 1'b0;
      end else begin
         err_q <= cfg_we_i && (locked_q || !idx_ok);
         if (cfg_lock_i) begin
            locked_q <= 1'b1;
         end
         // Uses the pre-edge lock, so a write paired with the lock request still lands.
         if (wr_ok) begin
            base_q[cfg_idx_i] <= cfg_base_i;
            len_q[cfg_idx_i]  <= cfg_len_i;
         end
         if (s1_adv) begin
            s1_valid_q <= req_valid_i;
            if (req_valid_i) begin
               s1_vec_q <= match_vec;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_idx_q   <= enc_idx;
               s2_hit_q   <= enc_hit;
               s2_multi_q <= enc_multi;
            end
         end
      end
   end

   assign resp_valid_o = s2_valid_q;
   assign resp_idx_o   = s2_idx_q;
   assign resp_hit_o   = s2_hit_q;
   assign resp_multi_o = s2_multi_q;
   assign cfg_locked_o = locked_q;
   assign cfg_err_o    = err_q;

endmodule
